// File: rtl/dot_stream_accum.sv
// dot_stream_accum: streaming pipelined dot product with per-vector accumulate.
// Ports: clk/reset; in_* beat stream (valid/ready); out_* result stream.
module dot_stream_accum #(
  parameter  int DATA_WIDTH = 16,
  parameter  int LANES      = 8,
  parameter  int MAX_BEATS  = 16,
  localparam int ACC_WIDTH  =
    2*DATA_WIDTH + $clog2(LANES*MAX_BEATS) + 1,
  localparam int BW         = $clog2(MAX_BEATS+1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*DATA_WIDTH-1:0] in_a,
  input  logic [LANES*DATA_WIDTH-1:0] in_b,
  input  logic                        in_last,
  input  logic                        in_signed,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ACC_WIDTH-1:0]        out_data,
  output logic [BW-1:0]               out_beats,
  output logic                        out_trunc
);

  localparam int LVL = $clog2(LANES);
  localparam int PW  = 2*DATA_WIDTH + 2;

  logic                        w_en;
  logic                        w_acc;
  logic                        w_cap;
  logic                        w_last;
  logic                        w_trunc;

  logic [BW-1:0]               r_in_cnt;
  logic [LVL:0]                r_vld;
  logic [LVL:0]                r_lst;
  logic [LVL:0]                r_trc;

  logic [PW-1:0]               w_ea   [LANES];
  logic [PW-1:0]               w_eb   [LANES];
  logic [PW-1:0]               w_m    [LANES];
  logic signed [ACC_WIDTH-1:0] w_prod [LANES];

  // Heap-ordered tree: leaves at LANES..2*LANES-1, root at 1.
  logic signed [ACC_WIDTH-1:0] r_node [1:2*LANES-1];

  logic signed [ACC_WIDTH-1:0] r_acc;
  logic [BW-1:0]               r_cnt;
  logic                        r_out_valid;
  logic [ACC_WIDTH-1:0]        r_out_data;
  logic [BW-1:0]               r_out_beats;
  logic                        r_out_trunc;

  assign w_en    = !(r_out_valid && !out_ready);
  assign w_acc   = in_valid && w_en;
  assign w_cap   = (r_in_cnt == BW'(MAX_BEATS-1));
  assign w_last  = in_last || w_cap;
  assign w_trunc = w_cap && !in_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_in_cnt <= '0;
    end else if (w_acc) begin
      r_in_cnt <= w_last ? '0 : r_in_cnt + BW'(1);
    end
  end

  // Operands extended to PW bits: the low PW bits of the
  // product are exact in either mode, then sign-extended.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      w_ea[i] = {{(PW-DATA_WIDTH){in_signed &
                 in_a[i*DATA_WIDTH+DATA_WIDTH-1]}},
                 in_a[i*DATA_WIDTH +: DATA_WIDTH]};
      w_eb[i] = {{(PW-DATA_WIDTH){in_signed &
                 in_b[i*DATA_WIDTH+DATA_WIDTH-1]}},
                 in_b[i*DATA_WIDTH +: DATA_WIDTH]};
      w_m[i]    = w_ea[i] * w_eb[i];
      w_prod[i] = ACC_WIDTH'(signed'(w_m[i]));
    end
  end

  // Every node registers each enabled cycle, so each tree
  // level is one pipeline stage; root is valid with tag LVL.
  always_ff @(posedge clk) begin
    if (w_en) begin
      for (int i = 0; i < LANES; i++) begin
        r_node[LANES+i] <= w_prod[i];
      end
      for (int j = 1; j < LANES; j++) begin
        r_node[j] <= r_node[2*j] + r_node[2*j+1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld <= '0;
      r_lst <= '0;
      r_trc <= '0;
    end else if (w_en) begin
      r_vld <= {r_vld[LVL-1:0], w_acc};
      r_lst <= {r_lst[LVL-1:0], w_last};
      r_trc <= {r_trc[LVL-1:0], w_trunc};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_beats <= '0;
      r_out_trunc <= 1'b0;
    end else if (w_en && r_vld[LVL] && r_lst[LVL]) begin
      r_out_data  <= r_acc + r_node[1];
      r_out_beats <= r_cnt + BW'(1);
      r_out_trunc <= r_trc[LVL];
      r_out_valid <= 1'b1;
      r_acc       <= '0;
      r_cnt       <= '0;
    end else begin
      if (w_en && r_vld[LVL]) begin
        r_acc <= r_acc + r_node[1];
        r_cnt <= r_cnt + BW'(1);
      end
      if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready  = w_en;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_beats = r_out_beats;
  assign out_trunc = r_out_trunc;

endmodule

// File: tb/tb_dot_stream_accum.sv
// tb_dot_stream_accum: scoreboard bench for dot_stream_accum.
// Expected vector results are queued on accept, compared on output.
module tb_dot_stream_accum;

  localparam int DW  = 16;
  localparam int LN  = 8;
  localparam int MB  = 16;
  localparam int ACC = 2*DW + $clog2(LN*MB) + 1;
  localparam int BW  = $clog2(MB+1);
  localparam int LW  = LN*DW;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [LW-1:0]  in_a = '0;
  logic [LW-1:0]  in_b = '0;
  logic           in_last = 1'b0;
  logic           in_signed = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [ACC-1:0] out_data;
  logic [BW-1:0]  out_beats;
  logic           out_trunc;

  typedef struct packed {
    logic [ACC-1:0] data;
    logic [BW-1:0]  beats;
    logic           trunc;
  } res_t;

  res_t   q[$];
  res_t   m_exp;
  int     checks = 0;
  int     errors = 0;
  longint tb_acc = 0;
  int     tb_cnt = 0;

  always #5 clk = ~clk;

  dot_stream_accum #(
    .DATA_WIDTH(DW),
    .LANES(LN),
    .MAX_BEATS(MB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_a(in_a),
    .in_b(in_b),
    .in_last(in_last),
    .in_signed(in_signed),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_beats(out_beats),
    .out_trunc(out_trunc)
  );

  function automatic logic [LW-1:0] splat(int v);
    logic [LW-1:0] r;
    for (int i = 0; i < LN; i++) r[i*DW +: DW] = DW'(v);
    return r;
  endfunction

  function automatic longint lane_val(logic [DW-1:0] v, logic s);
    longint x;
    x = longint'(v);
    if (s && v[DW-1]) x = x - (longint'(1) << DW);
    return x;
  endfunction

  function automatic longint beat_sum(logic [LW-1:0] a,
                                      logic [LW-1:0] b,
                                      logic s);
    longint t;
    t = 0;
    for (int i = 0; i < LN; i++)
      t += lane_val(a[i*DW +: DW], s) * lane_val(b[i*DW +: DW], s);
    return t;
  endfunction

  task automatic model_accept(input logic [LW-1:0] a,
                              input logic [LW-1:0] b,
                              input logic last, input logic s);
    res_t r;
    tb_acc += beat_sum(a, b, s);
    tb_cnt++;
    if (last || tb_cnt == MB) begin
      r.data  = ACC'(tb_acc);
      r.beats = BW'(tb_cnt);
      r.trunc = !last && (tb_cnt == MB);
      q.push_back(r);
      tb_acc = 0;
      tb_cnt = 0;
    end
  endtask

  task automatic send_beat(input logic [LW-1:0] a,
                           input logic [LW-1:0] b,
                           input logic last, input logic s);
    int   n;
    logic rdy;
    n = 0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_last = last;
    in_signed = s;
    do begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 300);
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout in_ready=%0b required=1", rdy);
    end else begin
      model_accept(a, b, last, s);
    end
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!out_valid && n < 64) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result data=%0d required=none",
                 $signed(out_data));
      end else begin
        m_exp = q.pop_front();
        if (out_data !== m_exp.data ||
            out_beats !== m_exp.beats ||
            out_trunc !== m_exp.trunc) begin
          errors++;
          $display("FAIL sb_result got=%0d/%0d/%0b required=%0d/%0d/%0b",
                   $signed(out_data), out_beats, out_trunc,
                   $signed(m_exp.data), m_exp.beats, m_exp.trunc);
        end
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 ||
        out_beats !== '0 || out_trunc !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got=%0b/%0d/%0d/%0b required=0/0/0/0",
               out_valid, out_data, out_beats, out_trunc);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got=%0b required=1", in_ready);
    end
  endtask

  task automatic test_single();
    logic [LW-1:0] a;
    int n;
    for (int i = 0; i < LN; i++) a[i*DW +: DW] = DW'(i + 1);
    send_beat(a, splat(1), 1'b1, 1'b1);
    n = 1;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n != 5) begin
      errors++;
      $display("FAIL latency got=%0d required=5", n);
    end
    checks++;
    if (out_data !== ACC'(36) || out_beats !== BW'(1) ||
        out_trunc !== 1'b0) begin
      errors++;
      $display("FAIL single_result got=%0d/%0d/%0b required=36/1/0",
               $signed(out_data), out_beats, out_trunc);
    end
    wait_drain();
  endtask

  task automatic test_sign_modes();
    send_beat(splat(16'hFFFF), splat(2), 1'b0, 1'b1);
    send_beat(splat(16'hFFFF), splat(2), 1'b1, 1'b1);
    send_beat(splat(16'hFFFF), splat(2), 1'b0, 1'b0);
    send_beat(splat(16'hFFFF), splat(2), 1'b1, 1'b0);
    wait_valid();
    checks++;
    if (!out_valid || out_data !== ACC'(-32) || out_beats !== BW'(2)) begin
      errors++;
      $display("FAIL signed_result got=%0d/%0d required=-32/2",
               $signed(out_data), out_beats);
    end
    @(posedge clk);
    #1;
    wait_valid();
    checks++;
    if (!out_valid || out_data !== ACC'(2097120)) begin
      errors++;
      $display("FAIL unsigned_result got=%0d required=2097120",
               out_data);
    end
    wait_drain();
  endtask

  task automatic test_back_to_back();
    send_beat(splat(1), splat(1), 1'b0, 1'b1);
    send_beat(splat(1), splat(1), 1'b1, 1'b1);
    send_beat(splat(3), splat(2), 1'b1, 1'b1);
    wait_valid();
    checks++;
    if (!out_valid || out_data !== ACC'(16) || out_beats !== BW'(2)) begin
      errors++;
      $display("FAIL b2b_first got=%0d/%0d required=16/2",
               $signed(out_data), out_beats);
    end
    @(posedge clk);
    #1;
    checks++;
    if (!out_valid || out_data !== ACC'(48) || out_beats !== BW'(1)) begin
      errors++;
      $display("FAIL b2b_second got=%0b/%0d/%0d required=1/48/1",
               out_valid, $signed(out_data), out_beats);
    end
    wait_drain();
  endtask

  task automatic test_backpressure();
    fork
      begin
        for (int j = 0; j < 6; j++)
          send_beat(splat(j + 1), splat(3), j == 2 || j == 5, 1'b1);
      end
      begin
        wait_valid();
        out_ready = 1'b0;
        repeat (10) begin
          @(negedge clk);
          checks++;
          if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
              out_data !== ACC'(144)) begin
            errors++;
            $display("FAIL stall_hold got=%0b/%0b/%0d required=0/1/144",
                     in_ready, out_valid, $signed(out_data));
          end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain();
  endtask

  task automatic test_truncation();
    for (int j = 0; j < MB; j++)
      send_beat(splat(1), splat(1), 1'b0, 1'b1);
    send_beat(splat(1), splat(1), 1'b1, 1'b1);
    wait_valid();
    checks++;
    if (!out_valid || out_data !== ACC'(128) ||
        out_beats !== BW'(16) || out_trunc !== 1'b1) begin
      errors++;
      $display("FAIL trunc_first got=%0d/%0d/%0b required=128/16/1",
               $signed(out_data), out_beats, out_trunc);
    end
    @(posedge clk);
    #1;
    checks++;
    if (!out_valid || out_data !== ACC'(8) ||
        out_beats !== BW'(1) || out_trunc !== 1'b0) begin
      errors++;
      $display("FAIL trunc_next got=%0d/%0d/%0b required=8/1/0",
               $signed(out_data), out_beats, out_trunc);
    end
    wait_drain();
  endtask

  task automatic test_reset_midvector();
    logic seen;
    send_beat(splat(1), splat(1), 1'b0, 1'b1);
    send_beat(splat(1), splat(1), 1'b0, 1'b1);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    q.delete();
    tb_acc = 0;
    tb_cnt = 0;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_in_ready got=%0b required=1", in_ready);
    end
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    @(posedge clk);
    #1;
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL rst_discard out_valid_seen=%0b required=0", seen);
    end
    send_beat(splat(2), splat(3), 1'b1, 1'b1);
    wait_valid();
    checks++;
    if (!out_valid || out_data !== ACC'(48) || out_beats !== BW'(1)) begin
      errors++;
      $display("FAIL rst_after got=%0d/%0d required=48/1",
               $signed(out_data), out_beats);
    end
    wait_drain();
  endtask

  task automatic test_random();
    logic done;
    done = 1'b0;
    fork
      begin
        for (int v = 0; v < 10; v++) begin
          int len;
          len = $urandom_range(1, 4);
          for (int j = 0; j < len; j++)
            send_beat({$urandom(), $urandom(), $urandom(), $urandom()},
                      {$urandom(), $urandom(), $urandom(), $urandom()},
                      j == len - 1, 1'($urandom_range(0, 1)));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_sign_modes();
    test_back_to_back();
    test_backpressure();
    test_truncation();
    test_reset_midvector();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dot_stream_accum.md
Name: dot_stream_accum

Overview:
Streaming, pipelined dot-product engine and the parametrised successor of the fixed-length adder-tree dot product. Vectors of any length up to LANES*MAX_BEATS elements arrive as LANES-wide beats over a valid/ready interface. Each beat is multiplied lane-wise and reduced through a registered log2(LANES)-level adder tree, then accumulated per vector. It adds backpressure, a per-beat signed/unsigned mode, and truncation detection. It is the compute core for the next matmul controller: one row·column product per vector.

Parameters:
DATA_WIDTH, 16, element width in bits.
LANES, 8, elements per beat; power of 2, >= 2.
MAX_BEATS, 16, maximum beats per vector; >= 1.
ACC_WIDTH (localparam), 2*DATA_WIDTH + $clog2(LANES*MAX_BEATS) + 1, accumulator/result width; two's complement in both modes.

Ports:
clk  in  1  clock.
reset  in  1  reset, synchronous, active-high.
in_valid  in  1  beat valid.
in_ready  out  1  beat accepted when in_valid && in_ready.
in_a  in  LANES*DATA_WIDTH  lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
in_b  in  LANES*DATA_WIDTH  same packing as in_a.
in_last  in  1  final beat of the current vector.
in_signed  in  1  1 = lanes treated as signed, 0 = unsigned; sampled per beat.
out_valid  out  1  result valid.
out_ready  in  1  result consumed when out_valid && out_ready.
out_data  out  ACC_WIDTH  dot product of the vector.
out_beats  out  $clog2(MAX_BEATS+1)  beats in the vector.
out_trunc  out  1  vector was force-terminated at MAX_BEATS.

Behaviour:
- Global pipeline enable: en = !(out_valid && !out_ready). in_ready = en. All stages, the accumulator and the output register advance only when en.
- Stage 0 (multiply register): LANES products, each extended to ACC_WIDTH. Signed mode sign-extends operands; unsigned mode zero-extends them.
- Stages 1..log2(LANES): registered pairwise adder tree. A beat sum emerges after T = 1 + log2(LANES) cycles.
- Beat tags (valid, last, trunc) travel with the data through every stage. Bubbles (valid = 0) never touch the accumulator.
- Accumulate stage, on a valid tagged beat:
  - Not last: acc <= acc + beat_sum; beat counter increments.
  - Last: out_data <= acc + beat_sum, out_beats <= count + 1, out_valid <= 1. acc and counter clear in the same cycle, so back-to-back vectors need no bubble.
- Latency: out_valid rises T+1 cycles after the last beat is accepted with no stall. Throughput is one beat per cycle.
- Truncation: the input-side beat counter marks the MAX_BEATS-th beat of a vector as last even when in_last = 0, and sets trunc. The next beat starts a new vector.
- out_valid clears on handshake unless a new result loads in the same cycle. out_data, out_beats and out_trunc hold stable while out_valid && !out_ready.
- Mixed in_signed within one vector is legal; each beat uses its own mode.
- No overflow is possible within ACC_WIDTH for any mode or length up to the limit.
- Reset (synchronous, any time, including mid-vector or mid-stall):
  - Clears all stage valids, acc, counters, out_valid, out_data = 0, out_beats = 0 and out_trunc = 0.
  - In-flight beats are discarded.
  - in_ready = 1 in the first cycle after reset.

Test Plan:
1. LANES=8. Single beat, a = 1..8, b = all 1, last = 1, signed -> out_data = 36, out_beats = 1, out_trunc = 0; out_valid exactly 5 cycles after accept.
2. Two beats, a = all 0xFFFF, b = all 2. Signed -> out_data = -32. Repeated unsigned -> out_data = 2097120.
3. Back-to-back vectors with no idle cycles: V1 = 2 beats (a = 1, b = 1) and V2 = 1 beat (a = 3, b = 2) -> results 16 then 48, in order, on consecutive enabled cycles, no cross-accumulation.
4. Stream 6 beats (vector ends at beat 3) while holding out_ready low 10 cycles once the first result appears -> in_ready low throughout the stall, out_data stable, both results correct after release, no beat lost or duplicated.
5. MAX_BEATS=16: 17 beats of a = 1, b = 1 with in_last never set -> first result 128, out_beats = 16, out_trunc = 1. The 17th beat begins a new vector; closing it with in_last gives 8, out_trunc = 0.
6. Assert reset after 2 beats of a 3-beat vector are accepted -> no output appears. A subsequent 1-beat vector (a = 2, b = 3) yields 48 with out_beats = 1.
